// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and packing helpers for the matrix loader.
// Build macro IDENTITY_PAD_EN: pad unused diagonal slots with +1 instead of 0.
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int N_MAX  = 5;
    localparam int MAT_W  = ELEM_W * N_MAX * N_MAX;
    localparam int SIZE_W = 3;

`ifdef IDENTITY_PAD_EN
    localparam logic [ELEM_W-1:0] PAD_DIAG = ELEM_W'(1);
`else
    localparam logic [ELEM_W-1:0] PAD_DIAG = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD
    } state_t;

    // Element (0,0) occupies the most significant byte of the packed word.
    function automatic logic [7:0] elem_lsb(input logic [SIZE_W-1:0] r, input logic [SIZE_W-1:0] c);
        return 8'(MAT_W - ELEM_W * (N_MAX * int'(r) + int'(c) + 1));
    endfunction

    function automatic logic is_legal_size(input logic [SIZE_W-1:0] s);
        return (s >= 3'd2) && (s <= 3'd5);
    endfunction

    function automatic logic [MAT_W-1:0] pad_pattern(input logic [SIZE_W-1:0] s);
        logic [MAT_W-1:0] p;
        p = '0;
        for (int k = 0; k < N_MAX; k++) begin
            if (k >= int'(s)) begin
                p[elem_lsb(3'(k), 3'(k)) +: ELEM_W] = PAD_DIAG;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Handshake bundle between the element source / matrix consumer and matrix_loader.
interface matrix_loader_if;
    import matrix_pkg::*;

    logic                start;
    logic [SIZE_W-1:0]   size;
    logic                size_err;
    logic                in_valid;
    logic                in_ready;
    logic [ELEM_W-1:0]   in_data;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [MAT_W-1:0]    matrix_out;
    logic [SIZE_W-1:0]   size_out;

    modport slave (
        input  start, size, in_valid, in_data, out_ready,
        output size_err, in_ready, busy, out_valid, matrix_out, size_out
    );

    modport master (
        output start, size, in_valid, in_data, out_ready,
        input  size_err, in_ready, busy, out_valid, matrix_out, size_out
    );

endinterface

// File: rtl/matrix_pos_counter.sv
// Row-major (row, col) write pointer wrapping at the latched matrix order.
module matrix_pos_counter
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [SIZE_W-1:0] size_i,
    output logic [SIZE_W-1:0] row_o,
    output logic [SIZE_W-1:0] col_o,
    output logic              last_o
);

    logic [SIZE_W-1:0] row_q, row_d;
    logic [SIZE_W-1:0] col_q, col_d;

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == size_i - 3'd1) && (col_q == size_i - 3'd1);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_q == size_i - 3'd1) begin
                col_d = '0;
                row_d = last_o ? '0 : row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Serial-to-parallel loader packing a 2x2..5x5 matrix into the 200-bit 5x5 word.
// Padding of unused positions depends on the IDENTITY_PAD_EN macro (see matrix_pkg).
module matrix_loader
    import matrix_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    matrix_loader_if.slave  bus
);

    state_t             state_q, state_d;
    logic [MAT_W-1:0]   matrix_q, matrix_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic               size_err_q, size_err_d;

    logic               cnt_clear;
    logic               cnt_advance;
    logic [SIZE_W-1:0]  row;
    logic [SIZE_W-1:0]  col;
    logic               last;

    matrix_pos_counter u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (cnt_clear),
        .advance_i (cnt_advance),
        .size_i    (size_q),
        .row_o     (row),
        .col_o     (col),
        .last_o    (last)
    );

    // A start seen in LOAD aborts the current load exactly as if issued from IDLE.
    always_comb begin
        state_d     = state_q;
        matrix_d    = matrix_q;
        size_d      = size_q;
        size_err_d  = 1'b0;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (bus.start) begin
                    if (is_legal_size(bus.size)) begin
                        size_d    = bus.size;
                        matrix_d  = pad_pattern(bus.size);
                        cnt_clear = 1'b1;
                        state_d   = ST_LOAD;
                    end else begin
                        size_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else if (state_q == ST_LOAD && bus.in_valid) begin
                    matrix_d[elem_lsb(row, col) +: ELEM_W] = bus.in_data;
                    cnt_advance = 1'b1;
                    if (last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            matrix_q   <= '0;
            size_q     <= '0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            matrix_q   <= matrix_d;
            size_q     <= size_d;
            size_err_q <= size_err_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_LOAD);
    assign bus.out_valid  = (state_q == ST_HOLD);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.size_err   = size_err_q;
    assign bus.matrix_out = matrix_q;
    assign bus.size_out   = size_q;

endmodule
